// File: rtl/mlp_stream_loader.sv
// mlp_stream_loader: deserialises a framed valid/ready byte stream into the
//   weight, bias and input arrays consumed by mlp, and flags when they are usable.
// Latency: each byte lands in its array slot on its accept edge; params_valid_o,
//   din_valid_o and err_o change on the edge that accepts the last byte of a frame.
// Backpressure: none; s_ready_o is 1 in every non-reset cycle.
//
// Ports:
//   clk_i, rst_i               clock (rising edge), asynchronous active-high reset
//   s_data_i/s_valid_i/s_ready_o  byte stream in
//   w1_o, b1_o, w2_o, b2_o     layer parameters for mlp
//   din_o                      input feature vector for mlp
//   params_valid_o             level: a complete parameter set is loaded
//   din_valid_o                1-cycle pulse: new input vector with valid parameters
//   err_o                      1-cycle pulse: bad command, checksum, or input
//                              vector arriving with no parameters loaded
//
// Frame format: command byte (0x01 parameters, 0x02 input vector) then payload.
// Parameter payload order: w1[i][j] (j fastest), b1[j], w2[j][k] (k fastest), b2[k].
// Build option MLP_STREAM_LOADER_CHECKSUM_EN: every frame carries a trailing byte
//   equal to the mod-256 sum of the command and payload bytes.

module mlp_stream_loader #(
  parameter int D_IN  = 6,
  parameter int D_HID = 16,
  parameter int D_OUT = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  output logic       s_ready_o,
  output logic [7:0] w1_o [D_IN][D_HID],
  output logic [7:0] b1_o [D_HID],
  output logic [7:0] w2_o [D_HID][D_OUT],
  output logic [7:0] b2_o [D_OUT],
  output logic [7:0] din_o [D_IN],
  output logic       params_valid_o,
  output logic       din_valid_o,
  output logic       err_o
);

  // Offsets of each array inside the parameter payload.
  localparam int OFF_B1 = D_IN * D_HID;
  localparam int OFF_W2 = OFF_B1 + D_HID;
  localparam int OFF_B2 = OFF_W2 + D_HID * D_OUT;
  localparam int NP     = OFF_B2 + D_OUT;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD_P = 2'd1;
  localparam logic [1:0] ST_LOAD_X = 2'd2;
  localparam logic [1:0] ST_CHK    = 2'd3;

  localparam logic [7:0] CMD_P = 8'h01;
  localparam logic [7:0] CMD_X = 8'h02;

  logic [1:0] state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic       pv_q, pv_d;
  logic       dv_q, dv_d;
  logic       err_q, err_d;
  logic       rdy_q;
  logic       accept;
  logic       wr_p, wr_x;

`ifdef MLP_STREAM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       is_p_q, is_p_d;
`endif

  logic [7:0] w1_q  [D_IN][D_HID];
  logic [7:0] b1_q  [D_HID];
  logic [7:0] w2_q  [D_HID][D_OUT];
  logic [7:0] b2_q  [D_OUT];
  logic [7:0] din_q [D_IN];

  assign accept = s_valid_i & rdy_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pv_d    = pv_q;
    dv_d    = 1'b0;
    err_d   = 1'b0;
    wr_p    = 1'b0;
    wr_x    = 1'b0;
`ifdef MLP_STREAM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
    is_p_d  = is_p_q;
`endif
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          idx_d = 8'd0;
`ifdef MLP_STREAM_LOADER_CHECKSUM_EN
          sum_d = s_data_i;
`endif
          if (s_data_i == CMD_P) begin
            state_d = ST_LOAD_P;
            pv_d    = 1'b0;  // a half-loaded parameter set must not be used
`ifdef MLP_STREAM_LOADER_CHECKSUM_EN
            is_p_d  = 1'b1;
`endif
          end else if (s_data_i == CMD_X) begin
            state_d = ST_LOAD_X;
`ifdef MLP_STREAM_LOADER_CHECKSUM_EN
            is_p_d  = 1'b0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
        ST_LOAD_P: begin
          wr_p  = 1'b1;
          idx_d = idx_q + 8'd1;
`ifdef MLP_STREAM_LOADER_CHECKSUM_EN
          sum_d = sum_q + s_data_i;
          if (idx_q == 8'(NP - 1)) state_d = ST_CHK;
`else
          if (idx_q == 8'(NP - 1)) begin
            state_d = ST_IDLE;
            pv_d    = 1'b1;
          end
`endif
        end
        ST_LOAD_X: begin
          wr_x  = 1'b1;
          idx_d = idx_q + 8'd1;
`ifdef MLP_STREAM_LOADER_CHECKSUM_EN
          sum_d = sum_q + s_data_i;
          if (idx_q == 8'(D_IN - 1)) state_d = ST_CHK;
`else
          if (idx_q == 8'(D_IN - 1)) begin
            state_d = ST_IDLE;
            dv_d    = pv_q;
            err_d   = ~pv_q;
          end
`endif
        end
`ifdef MLP_STREAM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          state_d = ST_IDLE;
          if (s_data_i != sum_q) begin
            err_d = 1'b1;
          end else if (is_p_q) begin
            pv_d = 1'b1;
          end else begin
            dv_d  = pv_q;
            err_d = ~pv_q;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= 8'd0;
      pv_q    <= 1'b0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef MLP_STREAM_LOADER_CHECKSUM_EN
      sum_q   <= 8'd0;
      is_p_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pv_q    <= pv_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
`ifdef MLP_STREAM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
      is_p_q  <= is_p_d;
`endif
    end
  end

  // Array storage: the byte index is decoded against each slot's fixed
  // payload position, so no divider is needed to split it into row/column.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < D_IN; i++)
        for (int j = 0; j < D_HID; j++) w1_q[i][j] <= 8'd0;
      for (int j = 0; j < D_HID; j++) b1_q[j] <= 8'd0;
      for (int j = 0; j < D_HID; j++)
        for (int k = 0; k < D_OUT; k++) w2_q[j][k] <= 8'd0;
      for (int k = 0; k < D_OUT; k++) b2_q[k] <= 8'd0;
      for (int i = 0; i < D_IN; i++) din_q[i] <= 8'd0;
    end else begin
      if (wr_p) begin
        for (int i = 0; i < D_IN; i++)
          for (int j = 0; j < D_HID; j++)
            if (idx_q == 8'(i * D_HID + j)) w1_q[i][j] <= s_data_i;
        for (int j = 0; j < D_HID; j++)
          if (idx_q == 8'(OFF_B1 + j)) b1_q[j] <= s_data_i;
        for (int j = 0; j < D_HID; j++)
          for (int k = 0; k < D_OUT; k++)
            if (idx_q == 8'(OFF_W2 + j * D_OUT + k)) w2_q[j][k] <= s_data_i;
        for (int k = 0; k < D_OUT; k++)
          if (idx_q == 8'(OFF_B2 + k)) b2_q[k] <= s_data_i;
      end
      if (wr_x) begin
        for (int i = 0; i < D_IN; i++)
          if (idx_q == 8'(i)) din_q[i] <= s_data_i;
      end
    end
  end

  assign s_ready_o      = rdy_q;
  assign params_valid_o = pv_q;
  assign din_valid_o    = dv_q;
  assign err_o          = err_q;
  assign w1_o           = w1_q;
  assign b1_o           = b1_q;
  assign w2_o           = w2_q;
  assign b2_o           = b2_q;
  assign din_o          = din_q;

endmodule

// File: tb/tb_mlp_stream_loader.sv
// tb_mlp_stream_loader: self-checking bench for mlp_stream_loader.
// Expected din_valid_o / err_o pulses are queued when a frame is driven and
// popped whenever the DUT pulses; array contents are checked against a model.
// Define MLP_STREAM_LOADER_CHECKSUM_EN for both bench and RTL to cover the checksum build.

module tb_mlp_stream_loader;
  localparam int D_IN  = 6;
  localparam int D_HID = 16;
  localparam int D_OUT = 3;
  localparam int NP    = D_IN * D_HID + D_HID + D_HID * D_OUT + D_OUT;

  localparam int EV_DIN = 1;
  localparam int EV_ERR = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] w1  [D_IN][D_HID];
  logic [7:0] b1  [D_HID];
  logic [7:0] w2  [D_HID][D_OUT];
  logic [7:0] b2  [D_OUT];
  logic [7:0] din [D_IN];
  logic       params_valid;
  logic       din_valid;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  logic [7:0] pay   [256];
  logic [7:0] mdl_p [NP];

  mlp_stream_loader #(.D_IN(D_IN), .D_HID(D_HID), .D_OUT(D_OUT)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .s_data_i       (s_data),
    .s_valid_i      (s_valid),
    .s_ready_o      (s_ready),
    .w1_o           (w1),
    .b1_o           (b1),
    .w2_o           (w2),
    .b2_o           (b2),
    .din_o          (din),
    .params_valid_o (params_valid),
    .din_valid_o    (din_valid),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  // Advance one cycle and score any pulse against the expected-event queue.
  task automatic tick();
    int code;
    int e;
    @(posedge clk);
    #1;
    if (din_valid === 1'b1 && err === 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL pulse_exclusive: din_valid_o=1 err_o=1, required not both high");
    end
    code = (din_valid === 1'b1) ? EV_DIN : (err === 1'b1) ? EV_ERR : 0;
    if (code != 0) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: got event %0d, required no pulse", code);
      end else begin
        e = exp_q.pop_front();
        if (code !== e) begin
          n_bad++;
          $display("FAIL pulse_kind: got event %0d, required %0d", code, e);
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    while (int'($urandom_range(99)) < gap_pct) begin
      s_valid = 1'b0;
      s_data  = 8'($urandom);
      tick();
    end
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  // Payload bytes come from pay[0..n-1].
  task automatic send_frame(input logic [7:0] cmd, input int n, input int gap_pct);
    logic [7:0] sum;
    sum = cmd;
    send_byte(cmd, gap_pct);
    for (int k = 0; k < n; k++) begin
      send_byte(pay[k], gap_pct);
      sum = sum + pay[k];
    end
`ifdef MLP_STREAM_LOADER_CHECKSUM_EN
    send_byte(sum, gap_pct);
`endif
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", name, got, want);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic check_params_model();
    for (int i = 0; i < D_IN; i++)
      for (int j = 0; j < D_HID; j++)
        check_byte($sformatf("w1[%0d][%0d]", i, j), w1[i][j], mdl_p[i * D_HID + j]);
    for (int j = 0; j < D_HID; j++)
      check_byte($sformatf("b1[%0d]", j), b1[j], mdl_p[D_IN * D_HID + j]);
    for (int j = 0; j < D_HID; j++)
      for (int k = 0; k < D_OUT; k++)
        check_byte($sformatf("w2[%0d][%0d]", j, k), w2[j][k],
                   mdl_p[D_IN * D_HID + D_HID + j * D_OUT + k]);
    for (int k = 0; k < D_OUT; k++)
      check_byte($sformatf("b2[%0d]", k), b2[k], mdl_p[NP - D_OUT + k]);
  endtask

  task automatic check_all_zero();
    for (int i = 0; i < D_IN; i++)
      for (int j = 0; j < D_HID; j++) check_byte("w1_zero", w1[i][j], 8'h00);
    for (int j = 0; j < D_HID; j++) check_byte("b1_zero", b1[j], 8'h00);
    for (int j = 0; j < D_HID; j++)
      for (int k = 0; k < D_OUT; k++) check_byte("w2_zero", w2[j][k], 8'h00);
    for (int k = 0; k < D_OUT; k++) check_byte("b2_zero", b2[k], 8'h00);
    for (int i = 0; i < D_IN; i++) check_byte("din_zero", din[i], 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_bit("rst_ready", s_ready, 1'b0);
    check_bit("rst_params_valid", params_valid, 1'b0);
    check_bit("rst_din_valid", din_valid, 1'b0);
    check_bit("rst_err", err, 1'b0);
    check_all_zero();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_bit("ready_after_rst", s_ready, 1'b1);
  endtask

  // Parameter frame with bytes pay[k] = base + k; params_valid must drop after the command.
  task automatic load_params(input logic [7:0] base, input int gap_pct);
    logic [7:0] sum;
    for (int k = 0; k < NP; k++) begin
      pay[k]   = base + 8'(k);
      mdl_p[k] = base + 8'(k);
    end
    send_byte(8'h01, gap_pct);
    check_bit("pv_cleared_after_cmd", params_valid, 1'b0);
    sum = 8'h01;
    for (int k = 0; k < NP; k++) begin
      send_byte(pay[k], gap_pct);
      sum = sum + pay[k];
    end
`ifdef MLP_STREAM_LOADER_CHECKSUM_EN
    send_byte(sum, gap_pct);
`endif
    check_bit("pv_after_load", params_valid, 1'b1);
    check_params_model();
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (3) tick();
    do_reset();
  endtask

  task automatic test_load_params();
    load_params(8'h00, 0);
    check_byte("t1_w1_0_0", w1[0][0], 8'h00);
    check_byte("t1_w1_5_15", w1[5][15], 8'h5F);
    check_byte("t1_b1_0", b1[0], 8'h60);
    check_byte("t1_w2_15_2", w2[15][2], 8'h9F);
    check_byte("t1_b2_2", b2[2], 8'hA2);
    repeat (3) tick();
    check_bit("t1_pv_level", params_valid, 1'b1);
  endtask

  task automatic test_load_input();
    for (int k = 0; k < D_IN; k++) pay[k] = 8'h11 + 8'(k);
    exp_q.push_back(EV_DIN);
    send_frame(8'h02, D_IN, 0);
    for (int k = 0; k < D_IN; k++) check_byte($sformatf("t2_din[%0d]", k), din[k], 8'h11 + 8'(k));
    tick();
    check_bit("t2_din_valid_one_cycle", din_valid, 1'b0);
    tick();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL t2_pulse_seen: %0d events outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_bad_cmd();
    exp_q.push_back(EV_ERR);
    send_byte(8'h7E, 0);
    tick();
    check_bit("t4_err_one_cycle", err, 1'b0);
    check_bit("t4_pv_kept", params_valid, 1'b1);
    check_params_model();
    load_params(8'h40, 0);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL t4_pulse_seen: %0d events outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_no_params();
    do_reset();
    for (int k = 0; k < D_IN; k++) pay[k] = 8'hA0 + 8'(k);
    exp_q.push_back(EV_ERR);
    send_frame(8'h02, D_IN, 0);
    for (int k = 0; k < D_IN; k++) check_byte($sformatf("t3_din[%0d]", k), din[k], 8'hA0 + 8'(k));
    tick();
    check_bit("t3_pv", params_valid, 1'b0);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL t3_pulse_seen: %0d events outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_gaps_reset();
    send_byte(8'h01, 50);
    for (int k = 0; k < 80; k++) send_byte(8'(k), 50);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_bit("t5_rst_pv", params_valid, 1'b0);
    check_bit("t5_rst_ready", s_ready, 1'b0);
    check_all_zero();
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_bit("t5_ready", s_ready, 1'b1);
    load_params(8'h00, 50);
    check_byte("t5_w1_5_15", w1[5][15], 8'h5F);
    check_byte("t5_b2_2", b2[2], 8'hA2);
  endtask

`ifdef MLP_STREAM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] sum;
    sum = 8'h02;
    exp_q.push_back(EV_DIN);
    send_byte(8'h02, 0);
    for (int k = 0; k < D_IN; k++) begin
      send_byte(8'h30 + 8'(k), 0);
      sum = sum + 8'h30 + 8'(k);
    end
    send_byte(sum, 0);
    tick();
    sum = 8'h02;
    exp_q.push_back(EV_ERR);
    send_byte(8'h02, 0);
    for (int k = 0; k < D_IN; k++) begin
      send_byte(8'h50 + 8'(k), 0);
      sum = sum + 8'h50 + 8'(k);
    end
    send_byte(sum + 8'h01, 0);
    tick();
    for (int k = 0; k < D_IN; k++) check_byte("t6_din_kept", din[k], 8'h50 + 8'(k));
    check_bit("t6_pv", params_valid, 1'b1);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL t6_pulse_seen: %0d events outstanding, required 0", exp_q.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_params();
    test_load_input();
    test_bad_cmd();
    test_no_params();
    test_gaps_reset();
`ifdef MLP_STREAM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (4) tick();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL final_queue: %0d events outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
